// File: rtl/avmm_mem_arbiter.sv
// avmm_mem_arbiter: round-robin share of one avmm_mem slave between N_MST
// Avalon-MM masters, one transaction in flight at a time.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   m_address/m_read/m_write/m_writedata   packed per-master requests
//   m_waitrequest       low only for the granted master in its issue cycle
//   m_readdata          shared registered read data
//   m_readdatavalid     one-cycle pulse to the master that owns the read
//   s_address/s_read/s_write/s_writedata/s_readdata  avmm_mem side
module avmm_mem_arbiter #(
  parameter int N_MST    = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MST*ADDR_W-1:0] m_address,
  input  logic [N_MST-1:0]        m_read,
  input  logic [N_MST-1:0]        m_write,
  input  logic [N_MST*DATA_W-1:0] m_writedata,
  output logic [N_MST-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]       m_readdata,
  output logic [N_MST-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]       s_address,
  output logic                    s_read,
  output logic                    s_write,
  output logic [DATA_W-1:0]       s_writedata,
  input  logic [DATA_W-1:0]       s_readdata
);

  localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RWAIT,
    RDATA
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [N_MST-1:0]  req;
  logic              found;
  logic [GW-1:0]     pick;
  logic [GW-1:0]     pick_nxt;

  logic [ADDR_W-1:0] addr_v [N_MST];
  logic [DATA_W-1:0] wd_v   [N_MST];

  for (genvar i = 0; i < N_MST; i++) begin : g_unpack
    assign addr_v[i] = m_address[i*ADDR_W +: ADDR_W];
    assign wd_v[i]   = m_writedata[i*DATA_W +: DATA_W];
  end

  assign req = m_read | m_write;

  // First requester at or above rr_ptr, wrapping to 0.
  always_comb begin : rr_pick
    int idx;
    int nxt;
    idx      = 0;
    nxt      = 0;
    found    = 1'b0;
    pick     = '0;
    pick_nxt = '0;
    for (int i = 0; i < N_MST; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_MST) idx = idx - N_MST;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
    nxt = int'(pick) + 1;
    if (nxt >= N_MST) nxt = 0;
    pick_nxt = GW'(nxt);
  end

  logic g_wr;
  logic g_rd;

  // Write wins when a master raises both strobes.
  assign g_wr = m_write[gnt_q];
  assign g_rd = m_read[gnt_q] & ~m_write[gnt_q];

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    ptr_d           = ptr_q;
    lat_d           = lat_q;
    rdata_d         = rdata_q;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    s_address       = '0;
    s_writedata     = '0;
    s_read          = 1'b0;
    s_write         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          ptr_d   = pick_nxt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        m_waitrequest[gnt_q] = 1'b0;
        s_address   = addr_v[gnt_q];
        s_writedata = wd_v[gnt_q];
        s_write     = g_wr;
        s_read      = g_rd;
        if (g_rd) begin
          lat_d   = LW'(READ_LAT - 1);
          state_d = RWAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RWAIT: begin
        if (lat_q == '0) begin
          rdata_d = s_readdata;
          state_d = RDATA;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RDATA: begin
        m_readdatavalid[gnt_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  assign m_readdata = rdata_q;

  // Flags a master that presents read and write together when granted.
  a_rd_wr_excl : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == ISSUE) |-> !(m_read[gnt_q] && m_write[gnt_q])
  ) else $warning("avmm_mem_arbiter: read and write both set on granted master");

endmodule

// File: tb/tb_avmm_mem_arbiter.sv
// tb_avmm_mem_arbiter: directed bench with a transaction-level model,
// an avmm_mem-style slave and per-cycle output comparison.
module tb_avmm_mem_arbiter;

  localparam int N   = 2;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];
  logic          rq_rd [N];
  logic          rq_wr [N];

  logic [N*AW-1:0] m_address;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N*DW-1:0] m_writedata;
  logic [N-1:0]    m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic [N-1:0]    m_readdatavalid;
  logic [AW-1:0]   s_address;
  logic            s_read;
  logic            s_write;
  logic [DW-1:0]   s_writedata;
  logic [DW-1:0]   s_readdata;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign m_address[i*AW +: AW]   = ad[i];
    assign m_writedata[i*DW +: DW] = wd[i];
    assign m_read[i]               = rq_rd[i];
    assign m_write[i]              = rq_wr[i];
  end

  avmm_mem_arbiter #(
    .N_MST(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  // avmm_mem slave, one-cycle read latency
  logic [DW-1:0] smem [256];
  logic [DW-1:0] srd = '0;
  always @(posedge clk) begin
    if (s_write) smem[s_address] <= s_writedata;
    if (s_read)  srd <= smem[s_address];
  end
  assign s_readdata = srd;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction model: cur = granted master (-1 none), t = cycles
  // since the grant decision; issue at t=1, data to master at t=2+LAT.
  int            cur = -1;
  int            t = 0;
  int            mptr = 0;
  logic [DW-1:0] exp_rd = '0;
  logic [DW-1:0] mmem [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur = -1; t = 0; mptr = 0;
    end else if (cur < 0) begin
      for (int k = 0; k < N; k++)
        if (cur < 0 && (rq_rd[(mptr+k)%N] || rq_wr[(mptr+k)%N]))
          cur = (mptr + k) % N;
      if (cur >= 0) begin
        mptr = (cur + 1) % N;
        t = 1;
      end
    end else if (t == 1) begin
      if (rq_wr[cur]) begin
        mmem[ad[cur]] = wd[cur];
        cur = -1;
      end else if (rq_rd[cur]) begin
        exp_rd = mmem[ad[cur]];
        t = 2;
      end else cur = -1;
    end else if (t < 2 + LAT) t++;
    else cur = -1;
  end

  always @(negedge clk) begin
    logic          iss;
    logic [N-1:0]  ew;
    logic [N-1:0]  ev;
    iss = (cur >= 0) && (t == 1);
    ew = iss ? ~(N'(1) << cur) : '1;
    ev = (cur >= 0 && t == 2 + LAT) ? (N'(1) << cur) : '0;
    chk("m_waitrequest", 64'(m_waitrequest), 64'(ew));
    chk("m_readdatavalid", 64'(m_readdatavalid), 64'(ev));
    chk("s_write", 64'(s_write), 64'(iss && rq_wr[cur]));
    chk("s_read", 64'(s_read),
        64'(iss && rq_rd[cur] && !rq_wr[cur]));
    chk("s_address", 64'(s_address), iss ? 64'(ad[cur]) : 64'(0));
    chk("s_writedata", 64'(s_writedata), iss ? 64'(wd[cur]) : 64'(0));
    if (ev != '0) chk("m_readdata", 64'(m_readdata), 64'(exp_rd));
    if (!rst_n) chk("m_readdata rst", 64'(m_readdata), 64'(0));
  end

  typedef struct {
    int            acc;
    int            val;
    logic [DW-1:0] rdata;
    logic          sw;
    logic          sr;
    logic [AW-1:0] sa;
    logic [DW-1:0] swd;
  } xr_t;

  // Starts at posedge+1; acc/val are cycle numbers counted from 0.
  task automatic xfer(input int m, input bit w, input bit r,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output xr_t x);
    x.acc = -1; x.val = -1; x.rdata = '0;
    x.sw = 0; x.sr = 0; x.sa = '0; x.swd = '0;
    rq_wr[m] = w; rq_rd[m] = r; ad[m] = a; wd[m] = d;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!m_waitrequest[m]) begin
        x.acc = c;
        x.sw = s_write; x.sr = s_read;
        x.sa = s_address; x.swd = s_writedata;
        break;
      end
    end
    @(posedge clk); #1;
    rq_wr[m] = 0; rq_rd[m] = 0; ad[m] = '0; wd[m] = '0;
    if (r && !w && x.acc >= 0) begin
      for (int c = x.acc + 1; c < x.acc + 12; c++) begin
        @(negedge clk);
        if (m_readdatavalid[m]) begin
          x.val = c;
          x.rdata = m_readdata;
          break;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic rst_pulse();
    rst_n = 0; #2; rst_n = 1;
    @(posedge clk); #1;
  endtask

  xr_t r0, r1;
  int  pulses;

  initial begin
    for (int i = 0; i < 256; i++) begin
      smem[i] = '0;
      mmem[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      ad[i] = '0; wd[i] = '0; rq_rd[i] = 0; rq_wr[i] = 0;
    end

    // Reset held while both masters request
    rq_wr[0] = 1; ad[0] = 8'h10;
    rq_rd[1] = 1; ad[1] = 8'h20;
    repeat (6) begin
      @(negedge clk);
      chk("rst waitrequest", 64'(m_waitrequest), 64'h3);
      chk("rst strobes", 64'({s_read, s_write}), 64'h0);
      chk("rst rdvalid", 64'(m_readdatavalid), 64'h0);
    end
    rq_wr[0] = 0; rq_rd[1] = 0; ad[0] = '0; ad[1] = '0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // M0 write
    xfer(0, 1, 0, 8'h10, 32'hDEADBEEF, r0);
    chk("wr accept cycle", 64'(r0.acc), 64'd1);
    chk("wr s_write", 64'({r0.sw, r0.sr}), 64'b10);
    chk("wr s_address", 64'(r0.sa), 64'h10);
    chk("wr s_writedata", 64'(r0.swd), 64'hDEADBEEF);

    // M0 read back
    xfer(0, 0, 1, 8'h10, '0, r0);
    chk("rd accept cycle", 64'(r0.acc), 64'd1);
    chk("rd s_read", 64'({r0.sw, r0.sr}), 64'b01);
    chk("rd valid cycle", 64'(r0.val), 64'd3);
    chk("rd data", 64'(r0.rdata), 64'hDEADBEEF);

    // Collision after reset: M0 first
    rst_pulse();
    fork
      xfer(0, 1, 0, 8'h01, 32'h11, r0);
      xfer(1, 1, 0, 8'h02, 32'h22, r1);
    join
    chk("coll1 m0 cycle", 64'(r0.acc), 64'd1);
    chk("coll1 m1 cycle", 64'(r1.acc), 64'd3);
    xfer(0, 0, 1, 8'h01, '0, r0);
    chk("coll1 readback", 64'(r0.rdata), 64'h11);

    // Last grant was M0, so M1 goes first now
    fork
      xfer(0, 1, 0, 8'h01, 32'h11, r0);
      xfer(1, 1, 0, 8'h02, 32'h22, r1);
    join
    chk("coll2 m1 cycle", 64'(r1.acc), 64'd1);
    chk("coll2 m0 cycle", 64'(r0.acc), 64'd3);
    xfer(1, 0, 1, 8'h02, '0, r1);
    chk("coll2 readback", 64'(r1.rdata), 64'h22);
    chk("coll2 rd cycle", 64'(r1.val), 64'd3);

    // M1 read aborted by reset during RWAIT
    rq_rd[1] = 1; ad[1] = 8'h02;
    r1.acc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!m_waitrequest[1]) begin
        r1.acc = c;
        break;
      end
    end
    chk("abort accept cycle", 64'(r1.acc), 64'd1);
    @(posedge clk); #1;
    rq_rd[1] = 0; ad[1] = '0;
    rst_pulse();
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_readdatavalid != '0) pulses++;
    end
    chk("abort no valid", 64'(pulses), 64'd0);
    chk("abort readdata", 64'(m_readdata), 64'h0);
    @(posedge clk); #1;
    fork
      xfer(0, 1, 0, 8'h03, 32'h33, r0);
      xfer(1, 1, 0, 8'h04, 32'h44, r1);
    join
    chk("abort ptr m0", 64'(r0.acc), 64'd1);
    chk("abort ptr m1", 64'(r1.acc), 64'd3);

    // Read and write together: write wins
    xfer(0, 1, 1, 8'h05, 32'h55, r0);
    chk("rw accept cycle", 64'(r0.acc), 64'd1);
    chk("rw strobes", 64'({r0.sw, r0.sr}), 64'b10);
    xfer(0, 0, 1, 8'h05, '0, r0);
    chk("rw readback", 64'(r0.rdata), 64'h55);

    // Single requester back-to-back
    xfer(1, 1, 0, 8'h06, 32'h66, r1);
    chk("b2b first", 64'(r1.acc), 64'd1);
    xfer(1, 1, 0, 8'h07, 32'h77, r1);
    chk("b2b second", 64'(r1.acc), 64'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
